// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular FIFO feeding the UART transmitter; head is read combinationally.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
// buffer; otherwise a single holding register gives one byte of lookahead.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic                   serial_out,
  output logic                   tx_busy
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W         = $clog2(CYCLES_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_config
    $error("uart_tx_buffered: CYCLES_PER_BIT must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  uart_state_t            state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] head;
  logic                   buf_full;
  logic                   buf_empty;
  logic                   push;
  logic                   pop;
  logic                   baud_done;

  assign data_in_ready = !buf_full;
  assign push          = data_in_valid && data_in_ready;
  assign baud_done     = (baud_cnt == BAUD_LAST);
  assign pop           = !buf_empty && ((state == IDLE) || (state == STOP && baud_done));
  assign tx_busy       = (state != IDLE) || !buf_empty;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (data_in),
    .push      (push),
    .pop       (pop),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty)
  );
`else
  logic [UART_DATA_W-1:0] hold_reg;
  logic                   hold_full;

  // Push needs !full and pop needs full, so they never coincide here.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_reg  <= data_in;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  assign head      = hold_reg;
  assign buf_full  = hold_full;
  assign buf_empty = !hold_full;
`endif

  // serial_out is set together with the state change so the line comes
  // straight from a flop and each bit lasts exactly CYCLES_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (pop) begin
            shift      <= head;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            serial_out <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt   <= '0;
            serial_out <= shift[0];
            state      <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              shift      <= shift >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
              serial_out <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift      <= head;
              bit_cnt    <= '0;
              serial_out <= 1'b0;
              state      <= START;
            end else begin
              serial_out <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered at 50 cycles per bit.
module tb_uart_tx_buffered;

  localparam int CPB        = 50;
  localparam int FRAME_CYC  = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int EXP_FULL_ACCEPTS = 9;
  localparam int EXP_QUEUED       = 3;
`else
  localparam int EXP_FULL_ACCEPTS = 2;
  localparam int EXP_QUEUED       = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;

  int checks = 0;
  int passes = 0;

  uart_tx_buffered #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then performs one handshake.
  task automatic applyStimulus(input logic [7:0] b);
    for (int c = 0; c < 700; c++) begin
      if (data_in_ready) break;
      tick();
    end
    checkOutput("push_ready", {31'd0, data_in_ready}, 32'd1);
    data_in       = b;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic waitStart(input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 700; c++) begin
      if (serial_out === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput({tag, "_start_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Entered at the first sample of the start bit; checks every cycle of the frame.
  task automatic checkFrame(input logic [7:0] exp_byte, input string tag);
    logic [9:0] frame;
    logic [7:0] decoded;
    int         errs;
    int         idx;
    frame   = {1'b1, exp_byte, 1'b0};
    decoded = '0;
    errs    = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      idx = i / CPB;
      if (serial_out !== frame[idx]) errs++;
      if ((i % CPB) == CPB / 2 && idx >= 1 && idx <= 8) decoded[idx-1] = serial_out;
      tick();
    end
    checkOutput({tag, "_bit_errors"}, errs, 0);
    checkOutput({tag, "_byte"}, {24'd0, decoded}, {24'd0, exp_byte});
  endtask

  task automatic checkIdleLine(input int cycles, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (serial_out !== 1'b1) lows++;
      tick();
    end
    checkOutput({tag, "_low_cycles"}, lows, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst [4];
    logic [7:0] full_bytes [10];
    logic [7:0] queued [3];
    int         k;
    logic       sampled;
    logic       prev_serial;

    // Reset state and a quiet line
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_serial", {31'd0, serial_out}, 32'd1);
    checkOutput("rst_ready", {31'd0, data_in_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
    rst = 1'b0;
    checkIdleLine(1000, "idle");

    // Single byte: exact latency and frame shape
    applyStimulus(8'h78);
    checkOutput("single_n_serial", {31'd0, serial_out}, 32'd1);
    checkOutput("single_n_busy", {31'd0, tx_busy}, 32'd1);
    tick();
    checkOutput("single_n1_serial", {31'd0, serial_out}, 32'd0);
    checkFrame(8'h78, "single");
    checkOutput("single_busy_end", {31'd0, tx_busy}, 32'd0);
    tick();

    // Burst of four contiguous frames
    burst = '{8'h78, 8'h79, 8'h7A, 8'h0D};
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(burst[i]);
      end
      begin
        waitStart("burst");
        for (int i = 0; i < 4; i++) checkFrame(burst[i], $sformatf("burst%0d", i));
      end
    join
    checkOutput("burst_busy_end", {31'd0, tx_busy}, 32'd0);
    tick();

    // Buffer full with valid held high
    for (int i = 0; i < 10; i++) full_bytes[i] = 8'h41 + 8'(i);
    fork
      begin
        k             = 0;
        data_in       = full_bytes[0];
        data_in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
          sampled = data_in_ready;
          tick();
          if (sampled) begin
            k++;
            if (k < 10) data_in = full_bytes[k];
          end
        end
        checkOutput("full_accepts", k, EXP_FULL_ACCEPTS);
        checkOutput("full_ready_low", {31'd0, data_in_ready}, 32'd0);
        prev_serial = serial_out;
        for (int c = 0; c < 700; c++) begin
          if (data_in_ready) break;
          prev_serial = serial_out;
          tick();
        end
        checkOutput("full_ready_back", {31'd0, data_in_ready}, 32'd1);
        checkOutput("full_ready_at_pop", {30'd0, prev_serial, serial_out}, 32'b10);
        for (int c = 0; c < 6000 && k < 10; c++) begin
          sampled = data_in_ready;
          tick();
          if (sampled) begin
            k++;
            if (k < 10) data_in = full_bytes[k];
          end
        end
        data_in_valid = 1'b0;
        checkOutput("full_all_accepted", k, 10);
      end
      begin
        waitStart("full");
        for (int i = 0; i < 10; i++) checkFrame(full_bytes[i], $sformatf("full%0d", i));
      end
    join
    checkOutput("full_busy_end", {31'd0, tx_busy}, 32'd0);
    tick();

    // Reset mid-frame during data bit 3 of 0x55 with bytes queued
    queued = '{8'h11, 8'h22, 8'h33};
    applyStimulus(8'h55);
    k             = 0;
    data_in       = queued[0];
    data_in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sampled = data_in_ready && data_in_valid;
      tick();
      if (sampled) begin
        k++;
        if (k < 3) data_in = queued[k];
        else data_in_valid = 1'b0;
      end
    end
    data_in_valid = 1'b0;
    checkOutput("rst_queued", k, EXP_QUEUED);
    repeat (226 - 4) tick();
    checkOutput("rst_bit3_value", {31'd0, serial_out}, 32'd0);
    checkOutput("rst_busy_before", {31'd0, tx_busy}, 32'd1);
    rst           = 1'b1;
    data_in       = 8'hAA;
    data_in_valid = 1'b1;
    tick();
    checkOutput("rst_mid_serial", {31'd0, serial_out}, 32'd1);
    checkOutput("rst_mid_ready", {31'd0, data_in_ready}, 32'd1);
    checkOutput("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    data_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checkIdleLine(700, "after_rst");
    checkOutput("after_rst_busy", {31'd0, tx_busy}, 32'd0);
    applyStimulus(8'h31);
    tick();
    checkOutput("post_rst_start", {31'd0, serial_out}, 32'd0);
    checkFrame(8'h31, "post_rst");
    checkIdleLine(700, "post_rst_tail");
    checkOutput("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
